cpu_muldiv: RTL and testbench
=============================

# cpu_muldiv

Parametrised multi-cycle multiply/divide unit for the mox125 core. It sits beside the execute stage and implements `MUL_L`, `DIV_L`, `UDIV_L`, `MOD_L` and `UMOD_L`. These are the operations the single-cycle execute path cannot close timing on. Execute launches an operation with a start pulse and stalls until the unit returns the result and the destination register index for writeback.

## Interface
- `WIDTH`, default 32: operand and result width; must be ≥ 4.
- `IDX_W`, default 4: register index width.
- `clk_i` in 1: clock. One clock domain.
- `rst_i` in 1: synchronous active-high reset.
- `flush_i` in 1: pipeline flush; aborts any operation in flight.
- `start_i` in 1: launch request; sampled only when `busy_o` = 0.
- `op_i` in 3: `MD_OP_MUL`, `MD_OP_DIV`, `MD_OP_UDIV`, `MD_OP_MOD` or `MD_OP_UMOD`.
- `a_i` in WIDTH: multiplicand or dividend.
- `b_i` in WIDTH: multiplier or divisor.
- `write_index_i` in IDX_W: destination register.
- `busy_o` out 1: an operation is in progress; execute must stall.
- `done_o` out 1: single-cycle pulse; `result_o` and `write_index_o` are valid.
- `result_o` out WIDTH: result; held until the next `done_o`.
- `write_index_o` out IDX_W: destination register captured at start.
- `div_zero_o` out 1: pulses with `done_o` when the divisor was 0.

## Operation
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- **IDLE**
  - `start_i` with MUL → MUL.
  - `start_i` with any divide op and `b_i` ≠ 0 → DIV.
  - `start_i` with any divide op and `b_i` = 0 → DONE.
  - Opcode and index are latched at start. Operands are latched as magnitudes for signed ops; result and remainder sign flags are latched at the same time.
- **MUL**: shift-add, one multiplier bit per cycle, step counter runs WIDTH−1 down to 0, then → DONE. Result is the low WIDTH bits of the product; signedness is irrelevant.
- **DIV**: restoring shift-subtract, one quotient bit per cycle, WIDTH cycles, then → FIX.
- **FIX**: sign correction.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Selects quotient (`DIV`/`UDIV`) or remainder (`MOD`/`UMOD`). → DONE.
- **DONE**: `done_o` = 1 for this cycle, → IDLE.
- Divide by zero:
  - `DIV`/`UDIV` return all-ones.
  - `MOD`/`UMOD` return `a_i` unchanged.
  - `div_zero_o` = 1.
- Signed overflow, MIN / −1: quotient is MIN and remainder is 0. This falls out of the magnitude datapath with no special case.
- `start_i` while `busy_o` = 1 is ignored; it is not queued.
- `flush_i` in any non-IDLE state → IDLE next cycle. No `done_o` is produced, and `result_o` keeps its previous value.
- `flush_i` and `start_i` asserted together: flush wins and the start is dropped.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `div_zero_o`, `result_o` and `write_index_o` all 0; counter 0.
- `busy_o` is high from the cycle after the start edge through the DONE cycle inclusive.
- Latency, measured from the start edge to the edge ending `done_o`:
  - MUL: WIDTH+1.
  - DIV/MOD: WIDTH+2.
  - Divide by zero: 1.
- Back-to-back: a new start is accepted in the cycle after DONE. Throughput is one op per latency+1 cycles.
- Inputs are consumed only at the start edge. After that, `a_i`, `b_i` and `op_i` may change freely.

## Configuration
- `MUL_FAST_EN`
  - Defined: MUL uses a single-cycle array product. IDLE → DONE directly, latency 1.
  - Undefined: MUL is iterative as above. Divide behaviour is identical either way.

## Structure
- `defines.h` holds:
  - `MD_OP_*` encodings (MUL=0, DIV=1, UDIV=2, MOD=3, UMOD=4).
  - State encodings `MD_STATE_*`.
- One natural sub-module, `cpu_muldiv_divstep`: a combinational single-bit restore step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - It is instantiated once; the MUL step stays inline.

## Test plan
- MUL 7 × 0xFFFFFFFD (WIDTH=32) → `result_o` = 0xFFFFFFEB, `done_o` 33 cycles after start, `busy_o` high throughout.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. MOD with the same operands → 0xFFFFFFFF. Each takes 34 cycles.
- UDIV 0xFFFFFFFF / 0x10 → 0x0FFFFFFF. UMOD with the same operands → 0xF.
- DIV 5 / 0 → 0xFFFFFFFF with `div_zero_o` = 1, 1 cycle latency. MOD 5 / 0 → 5.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. MOD with the same operands → 0.
- Flush, write index and start-while-busy:
  - Start DIV and assert `flush_i` at cycle 10 → no `done_o`, `busy_o` = 0 the next cycle, `result_o` unchanged.
  - An immediate new MUL 3 × 4 then completes with 0xC and `write_index_o` = the new index.
  - Start held high while busy → exactly one `done_o`.

Source files
------------

// File: rtl/cpu_muldiv_pkg.sv
// Shared opcode/state encodings and opcode helpers for the mox125 multiply/divide unit.
package cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_OP_MUL  = 3'd0,
    MD_OP_DIV  = 3'd1,
    MD_OP_UDIV = 3'd2,
    MD_OP_MOD  = 3'd3,
    MD_OP_UMOD = 3'd4
  } md_op_e;

  typedef enum logic [2:0] {
    MD_STATE_IDLE = 3'd0,
    MD_STATE_MUL  = 3'd1,
    MD_STATE_DIV  = 3'd2,
    MD_STATE_FIX  = 3'd3,
    MD_STATE_DONE = 3'd4
  } md_state_e;

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_MOD);
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return (op == MD_OP_MOD) || (op == MD_OP_UMOD);
  endfunction

endpackage

// File: rtl/cpu_muldiv_divstep.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module cpu_muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so the result fits WIDTH bits.
  assign shifted  = {rem, dividend_bit};
  assign trial    = shifted - {1'b0, divisor};
  assign q_bit    = ~trial[WIDTH];
  assign rem_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/cpu_muldiv.sv
// Multi-cycle multiply/divide unit beside the execute stage.
// Define MUL_FAST_EN for a single-cycle array multiplier; divide is unaffected.
module cpu_muldiv
  import cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [IDX_W-1:0] write_index_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [IDX_W-1:0] write_index_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_e        state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;

  // Signed divides run on magnitudes; signs are reapplied in FIX.
  assign a_mag    = (md_is_signed(op_i) && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag    = (md_is_signed(op_i) && b_i[WIDTH-1]) ? -b_i : b_i;
  assign mul_next = b_q[0] ? acc_q + a_q : acc_q;
  assign quot_fix = neg_q ? -a_q : a_q;
  assign rem_fix  = neg_r ? -acc_q : acc_q;

  // During DIV, a_q shifts the dividend out of its top and the quotient into its bottom.
  cpu_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem          (acc_q),
    .dividend_bit (a_q[WIDTH-1]),
    .divisor      (b_q),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= MD_STATE_IDLE;
      op_q          <= '0;
      count         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      acc_q         <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      div_zero_o    <= 1'b0;
      result_o      <= '0;
      write_index_o <= '0;
    end else begin
      done_o     <= 1'b0;
      div_zero_o <= 1'b0;
      if (flush_i && state != MD_STATE_IDLE) begin
        state  <= MD_STATE_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          MD_STATE_IDLE: begin
            if (start_i && !flush_i) begin
              op_q          <= op_i;
              write_index_o <= write_index_i;
              busy_o        <= 1'b1;
              count         <= CNT_W'(WIDTH - 1);
              acc_q         <= '0;
              if (op_i == MD_OP_MUL) begin
`ifdef MUL_FAST_EN
                result_o <= a_i * b_i;
                done_o   <= 1'b1;
                state    <= MD_STATE_DONE;
`else
                a_q   <= a_i;
                b_q   <= b_i;
                state <= MD_STATE_MUL;
`endif
              end else if (b_i == '0) begin
                result_o   <= md_is_rem(op_i) ? a_i : '1;
                div_zero_o <= 1'b1;
                done_o     <= 1'b1;
                state      <= MD_STATE_DONE;
              end else begin
                a_q   <= a_mag;
                b_q   <= b_mag;
                neg_q <= md_is_signed(op_i) && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                neg_r <= md_is_signed(op_i) && a_i[WIDTH-1];
                state <= MD_STATE_DIV;
              end
            end
          end
          MD_STATE_MUL: begin
            acc_q <= mul_next;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            if (count == '0) begin
              result_o <= mul_next;
              done_o   <= 1'b1;
              state    <= MD_STATE_DONE;
            end else begin
              count <= count - 1'b1;
            end
          end
          MD_STATE_DIV: begin
            acc_q <= rem_next;
            a_q   <= {a_q[WIDTH-2:0], q_bit};
            if (count == '0) begin
              state <= MD_STATE_FIX;
            end else begin
              count <= count - 1'b1;
            end
          end
          MD_STATE_FIX: begin
            result_o <= md_is_rem(op_q) ? rem_fix : quot_fix;
            done_o   <= 1'b1;
            state    <= MD_STATE_DONE;
          end
          MD_STATE_DONE: begin
            busy_o <= 1'b0;
            state  <= MD_STATE_IDLE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= MD_STATE_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_muldiv.sv
// Scoreboard bench for cpu_muldiv: driver pushes reference results, monitor pops on done_o.
module tb_cpu_muldiv;

  logic        clk;
  logic        rst_i;
  logic        flush_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [3:0]  write_index_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [3:0]  write_index_o;
  logic        div_zero_o;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  idx;
    logic        dz;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lastResult = '0;

  cpu_muldiv #(.WIDTH(32), .IDX_W(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .start_i       (start_i),
    .op_i          (op_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .write_index_i (write_index_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .result_o      (result_o),
    .write_index_o (write_index_o),
    .div_zero_o    (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference arithmetic: 0=MUL 1=DIV 2=UDIV 3=MOD 4=UMOD.
  function automatic void refModel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic dz);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    sa  = a;
    sb  = b;
    dz  = 1'b0;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (op == 3'd0) begin
      r = a * b;
    end else if (b == 32'd0) begin
      dz = 1'b1;
      r  = (op == 3'd3 || op == 3'd4) ? a : 32'hFFFF_FFFF;
    end else begin
      case (op)
        3'd1:    r = ovf ? 32'h8000_0000 : 32'(sa / sb);
        3'd3:    r = ovf ? 32'd0 : 32'(sa % sb);
        3'd4:    r = a % b;
        default: r = a / b;
      endcase
    end
  endfunction

  // Issue one op at a negedge with busy_o low; returns at the negedge after DONE.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] idx, input bit hold);
    logic [31:0] r;
    logic        dz;
    int          expLat;
    int          lat;
    bit          busyOk;
    refModel(op, a, b, r, dz);
    expQ.push_back('{res: r, idx: idx, dz: dz});
    lastResult    = r;
    expLat        = (op == 3'd0) ? 33 : ((b == 32'd0) ? 1 : 34);
    start_i       = 1'b1;
    op_i          = op;
    a_i           = a;
    b_i           = b;
    write_index_i = idx;
    lat           = 0;
    busyOk        = 1'b1;
    for (int k = 1; k <= 100 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        start_i       = 1'b0;
        op_i          = 3'($urandom_range(0, 4));
        a_i           = $urandom;
        b_i           = $urandom;
        write_index_i = 4'($urandom);
      end
      if (!busy_o) busyOk = 1'b0;
      if (done_o) lat = k;
    end
    start_i = 1'b0;
    checkOutput("latency", 64'(lat), 64'(expLat));
    checkOutput("busy_during_op", 64'(busyOk), 64'd1);
    @(negedge clk);
    checkOutput("busy_after_done", 64'(busy_o), 64'd0);
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst_i && done_o) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("result", 64'(result_o), 64'(e.res));
        checkOutput("write_index", 64'(write_index_o), 64'(e.idx));
        checkOutput("div_zero", 64'(div_zero_o), 64'(e.dz));
      end
    end
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;
    rst_i         = 1'b1;
    flush_i       = 1'b0;
    start_i       = 1'b1;
    op_i          = 3'd1;
    a_i           = 32'h1234_5678;
    b_i           = 32'd0;
    write_index_i = 4'hA;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy_o), 64'd0);
    checkOutput("reset_done", 64'(done_o), 64'd0);
    checkOutput("reset_div_zero", 64'(div_zero_o), 64'd0);
    checkOutput("reset_result", 64'(result_o), 64'd0);
    checkOutput("reset_index", 64'(write_index_o), 64'd0);
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk);

    applyStimulus(3'd0, 32'd7, 32'hFFFF_FFFD, 4'd1, 1'b0);
    applyStimulus(3'd1, 32'hFFFF_FFF9, 32'd2, 4'd2, 1'b0);
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 4'd3, 1'b0);
    applyStimulus(3'd2, 32'hFFFF_FFFF, 32'h10, 4'd4, 1'b0);
    applyStimulus(3'd4, 32'hFFFF_FFFF, 32'h10, 4'd5, 1'b0);
    applyStimulus(3'd1, 32'd5, 32'd0, 4'd6, 1'b0);
    applyStimulus(3'd3, 32'd5, 32'd0, 4'd7, 1'b0);
    applyStimulus(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 4'd8, 1'b0);
    applyStimulus(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 4'd9, 1'b0);
    applyStimulus(3'd2, 32'd5, 32'd0, 4'd10, 1'b0);
    applyStimulus(3'd4, 32'h8000_0000, 32'd0, 4'd11, 1'b0);

    // Flush a divide mid-flight: no done, busy drops, result holds.
    start_i       = 1'b1;
    op_i          = 3'd1;
    a_i           = 32'd1000;
    b_i           = 32'd7;
    write_index_i = 4'd12;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start_i = 1'b0;
      if (k == 10) flush_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0;
    checkOutput("flush_busy", 64'(busy_o), 64'd0);
    checkOutput("flush_done", 64'(done_o), 64'd0);
    checkOutput("flush_result_held", 64'(result_o), 64'(lastResult));
    applyStimulus(3'd0, 32'd3, 32'd4, 4'd13, 1'b0);

    // Flush and start together in IDLE: start is dropped.
    flush_i = 1'b1;
    start_i = 1'b1;
    op_i    = 3'd0;
    @(negedge clk);
    flush_i = 1'b0;
    start_i = 1'b0;
    checkOutput("flush_start_busy", 64'(busy_o), 64'd0);

    // Start held throughout the op yields exactly one done.
    applyStimulus(3'd2, 32'd100, 32'd9, 4'd14, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("held_start_idle", 64'(busy_o), 64'd0);
    checkOutput("result_held", 64'(result_o), 64'(lastResult));

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 4));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      applyStimulus(rop, ra, rb, 4'($urandom), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
